// File: rtl/strap_pkg.sv
// ============================================================================
// strap_pkg -- shared types and sizing helpers for the strap sampler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package strap_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  // Shared settle/sample counter width; covers SETTLE up to 65535 cycles.
  localparam int unsigned SETTLE_CNT_W = 16;

  function automatic int unsigned vote_cnt_w(input int unsigned samples);
    return $clog2(samples + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/strap_vote.sv
// ============================================================================
// strap_vote -- per-bit ones-counter with majority and unanimity outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module strap_vote
  import strap_pkg::*;
#(
  parameter int unsigned SAMPLES = 3
) (
  input  logic ck,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic maj,
  output logic unan
);

  localparam int unsigned VW = vote_cnt_w(SAMPLES);
  localparam logic [VW-1:0] C_HALF = VW'(SAMPLES / 2);
  localparam logic [VW-1:0] C_ALL  = VW'(SAMPLES);

  logic [VW-1:0] r_cnt;
  logic [VW-1:0] w_sum;

  // The sum includes the sample being taken this cycle so the verdict is
  // ready on the same edge that the last sample is counted.
  assign w_sum = r_cnt + VW'(en & d);

  always_ff @(posedge ck) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_sum;
    end
  end

  assign maj  = (w_sum > C_HALF);
  assign unan = (w_sum == '0) || (w_sum == C_ALL);

endmodule

`default_nettype wire

// File: rtl/strap_sampler.sv
// ============================================================================
// strap_sampler -- settle, N-sample majority vote and lock of strap inputs.
// Optional macro STRAP_PARITY_EN adds a voted even-parity strap and cfg_perr.
// Revision: 1.0
// ============================================================================
`default_nettype none

module strap_sampler
  import strap_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned SAMPLES = 3
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [WIDTH-1:0] strap_i,
  input  logic             resample,
`ifdef STRAP_PARITY_EN
  input  logic             strap_par,
  output logic             cfg_perr,
`endif
  output logic [WIDTH-1:0] cfg,
  output logic             cfg_valid,
  output logic             busy,
  output logic             mismatch
);

`ifdef STRAP_PARITY_EN
  localparam int unsigned NV = WIDTH + 1;
`else
  localparam int unsigned NV = WIDTH;
`endif

  localparam logic [SETTLE_CNT_W-1:0] C_SETTLE_LAST = SETTLE_CNT_W'(SETTLE - 1);
  localparam logic [SETTLE_CNT_W-1:0] C_SAMPLE_LAST = SETTLE_CNT_W'(SAMPLES - 1);
  localparam logic [SETTLE_CNT_W-1:0] C_ONE         = SETTLE_CNT_W'(1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SETTLE_CNT_W-1:0] r_cnt;
  logic [SETTLE_CNT_W-1:0] w_cnt_nxt;
  logic                    w_clr;
  logic                    w_en;
  logic                    w_lock;
  logic                    w_drop;
  logic [NV-1:0]           w_d;
  logic [NV-1:0]           w_maj;
  logic [NV-1:0]           w_unan;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    w_lock      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_SETTLE: begin
        if (r_cnt == C_SETTLE_LAST) begin
          w_state_nxt = ST_SAMPLE;
          w_cnt_nxt   = '0;
          w_clr       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      ST_SAMPLE: begin
        w_en = 1'b1;
        if (r_cnt == C_SAMPLE_LAST) begin
          w_state_nxt = ST_LOCK;
          w_cnt_nxt   = '0;
          w_lock      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      ST_LOCK: begin
        // Requests outside LOCK are dropped, never queued.
        if (resample) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = '0;
          w_drop      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_SETTLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      r_state <= ST_SETTLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef STRAP_PARITY_EN
  assign w_d = {strap_par, strap_i};
`else
  assign w_d = strap_i;
`endif

  generate
    for (genvar b = 0; b < NV; b++) begin : g_vote
      strap_vote #(
        .SAMPLES (SAMPLES)
      ) u_vote (
        .ck   (ck),
        .clr  (rst | w_clr),
        .en   (w_en),
        .d    (w_d[b]),
        .maj  (w_maj[b]),
        .unan (w_unan[b])
      );
    end
  endgenerate

  // cfg/mismatch only change at lock entry so consumers never see a
  // half-updated word across a resample.
  always_ff @(posedge ck) begin
    if (rst) begin
      cfg       <= '0;
      cfg_valid <= 1'b0;
      mismatch  <= 1'b0;
`ifdef STRAP_PARITY_EN
      cfg_perr  <= 1'b0;
`endif
    end else if (w_lock) begin
      cfg       <= w_maj[WIDTH-1:0];
      cfg_valid <= 1'b1;
      mismatch  <= ~(&w_unan);
`ifdef STRAP_PARITY_EN
      cfg_perr  <= ^w_maj;
`endif
    end else if (w_drop) begin
      cfg_valid <= 1'b0;
    end
  end

  assign busy = (r_state != ST_LOCK);

endmodule

`default_nettype wire

// File: tb/tb_strap_sampler.sv
// ============================================================================
// tb_strap_sampler -- directed vector bench for strap_sampler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_strap_sampler;

  logic       ck = 1'b0;
  logic       rst;
  logic       resample;
  logic [7:0] strap_i;
  logic [7:0] cfg;
  logic       cfg_valid;
  logic       busy;
  logic       mismatch;
`ifdef STRAP_PARITY_EN
  logic       strap_par;
  logic       cfg_perr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ck = ~ck;

  strap_sampler #(
    .WIDTH   (8),
    .SETTLE  (4),
    .SAMPLES (3)
  ) dut (
    .ck        (ck),
    .rst       (rst),
    .strap_i   (strap_i),
    .resample  (resample),
`ifdef STRAP_PARITY_EN
    .strap_par (strap_par),
    .cfg_perr  (cfg_perr),
`endif
    .cfg       (cfg),
    .cfg_valid (cfg_valid),
    .busy      (busy),
    .mismatch  (mismatch)
  );

  typedef struct {
    logic [7:0]  s0;
    logic [7:0]  s1;
    logic [7:0]  s2;
    logic [10:0] rsmask;
    logic [7:0]  cfg;
    logic        mm;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // Leaves the bench in cycle 0 (first cycle with rst low).
  task automatic do_reset();
    rst      = 1'b1;
    resample = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".cfg"},       32'(cfg),       32'h00);
    chk({tag, ".cfg_valid"}, 32'(cfg_valid), 32'h0);
    chk({tag, ".busy"},      32'(busy),      32'h1);
    chk({tag, ".mismatch"},  32'(mismatch),  32'h0);
  endtask

  initial begin
    rst      = 1'b1;
    resample = 1'b0;
    strap_i  = 8'h00;
`ifdef STRAP_PARITY_EN
    strap_par = 1'b0;
`endif

    //          s0     s1     s2     resample cycles      cfg    mm
    vt[0] = '{8'hA5, 8'hA5, 8'hA5, 11'b000_0000_0000, 8'hA5, 1'b0};
    vt[1] = '{8'h0F, 8'h1F, 8'h0F, 11'b000_0000_0000, 8'h0F, 1'b1};
    vt[2] = '{8'h1F, 8'h0F, 8'h1F, 11'b000_0000_0000, 8'h1F, 1'b1};
    vt[3] = '{8'hFF, 8'h00, 8'hFF, 11'b000_0000_0000, 8'hFF, 1'b1};
    vt[4] = '{8'h00, 8'h00, 8'h00, 11'b000_0000_0000, 8'h00, 1'b0};
    vt[5] = '{8'hA5, 8'hA5, 8'hA5, 11'b000_0010_0100, 8'hA5, 1'b0};
    vt[6] = '{8'hC3, 8'h3C, 8'hC3, 11'b000_0000_0000, 8'hC3, 1'b1};

    for (int v = 0; v < 7; v++) begin
      do_reset();
      chk_reset($sformatf("v%0d.reset", v));
      for (int c = 0; c < 11; c++) begin
        strap_i  = (c == 5) ? vt[v].s1 : (c >= 6) ? vt[v].s2 : vt[v].s0;
        resample = vt[v].rsmask[c];
        if (c < 7) begin
          chk($sformatf("v%0d.c%0d.busy", v, c),  32'(busy),      32'h1);
          chk($sformatf("v%0d.c%0d.valid", v, c), 32'(cfg_valid), 32'h0);
          chk($sformatf("v%0d.c%0d.cfg", v, c),   32'(cfg),       32'h00);
        end else begin
          chk($sformatf("v%0d.c%0d.busy", v, c),  32'(busy),      32'h0);
          chk($sformatf("v%0d.c%0d.valid", v, c), 32'(cfg_valid), 32'h1);
          chk($sformatf("v%0d.c%0d.cfg", v, c),   32'(cfg),       32'(vt[v].cfg));
          chk($sformatf("v%0d.c%0d.mm", v, c),    32'(mismatch),  32'(vt[v].mm));
        end
        tick();
      end
      resample = 1'b0;
    end

    // Resample: old word held until the new lock, then atomic update.
    do_reset();
    strap_i = 8'hA5;
    repeat (7) tick();
    chk("rs.lock0.cfg",   32'(cfg),       32'hA5);
    chk("rs.lock0.valid", 32'(cfg_valid), 32'h1);
    strap_i  = 8'h3C;
    resample = 1'b1;
    tick();
    resample = 1'b0;
    chk("rs.drop.valid", 32'(cfg_valid), 32'h0);
    chk("rs.drop.busy",  32'(busy),      32'h1);
    chk("rs.drop.cfg",   32'(cfg),       32'hA5);
    chk("rs.drop.mm",    32'(mismatch),  32'h0);
    for (int i = 1; i < 7; i++) begin
      tick();
      chk($sformatf("rs.hold%0d.cfg", i),   32'(cfg),       32'hA5);
      chk($sformatf("rs.hold%0d.valid", i), 32'(cfg_valid), 32'h0);
    end
    tick();
    chk("rs.lock1.cfg",   32'(cfg),       32'h3C);
    chk("rs.lock1.valid", 32'(cfg_valid), 32'h1);
    chk("rs.lock1.busy",  32'(busy),      32'h0);

    // Mid-operation reset during a resample sequence.
    do_reset();
    strap_i = 8'h0F;
    repeat (5) tick();
    strap_i = 8'h1F;
    tick();
    strap_i = 8'h0F;
    tick();
    chk("mr.lock0.cfg", 32'(cfg),      32'h0F);
    chk("mr.lock0.mm",  32'(mismatch), 32'h1);
    strap_i  = 8'hFF;
    resample = 1'b1;
    tick();
    resample = 1'b0;
    repeat (5) tick();
    chk("mr.c5.cfg",   32'(cfg),       32'h0F);
    chk("mr.c5.mm",    32'(mismatch),  32'h1);
    chk("mr.c5.valid", 32'(cfg_valid), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("mr.after");
    repeat (6) tick();
    chk("mr.c6.valid", 32'(cfg_valid), 32'h0);
    tick();
    chk("mr.lock1.cfg",   32'(cfg),       32'hFF);
    chk("mr.lock1.valid", 32'(cfg_valid), 32'h1);
    chk("mr.lock1.mm",    32'(mismatch),  32'h0);

`ifdef STRAP_PARITY_EN
    strap_i   = 8'h01;
    strap_par = 1'b0;
    do_reset();
    repeat (7) tick();
    chk("par.odd.perr", 32'(cfg_perr), 32'h1);
    strap_par = 1'b1;
    do_reset();
    chk("par.reset.perr", 32'(cfg_perr), 32'h0);
    repeat (7) tick();
    chk("par.even.perr", 32'(cfg_perr), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/strap_sampler.md
Name: strap_sampler

Overview:
- Samples a bank of configuration straps that are hard-tied to constant 0/1 by tie cells and presents them as a stable, majority-voted configuration word.
- Sits directly downstream of the tie-cell outputs and upstream of any logic that needs boot-time configuration.
- Settles after reset, then samples N times, votes, locks and flags disagreement.
- Supports software-requested re-sampling.

Parameters:
- WIDTH, 8: number of strap bits.
- SETTLE, 4: cycles waited after reset release or resample request before the first sample; minimum 1.
- SAMPLES, 3: number of consecutive samples voted; must be odd, 1..15.

Ports:
- ck  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- strap_i  input  WIDTH  strap levels from tie cells / pads.
- resample  input  1  single-cycle request to re-run settle+sample; honoured only in LOCK.
- cfg  output  WIDTH  voted configuration word.
- cfg_valid  output  1  high while cfg holds a locked result.
- busy  output  1  high in SETTLE or SAMPLE.
- mismatch  output  1  at least one bit was not unanimous across the last sample set.

Behaviour:
- One clock domain `ck`. Reset is synchronous and active-high on `rst`; this is fixed.
- Reset values:
  - state = SETTLE, counter = 0.
  - cfg = 0, cfg_valid = 0, busy = 1, mismatch = 0.
  - All vote counters = 0.
- States:
  - SETTLE: count SETTLE cycles. On the last one, go to SAMPLE, clear the vote counters and clear the sample counter.
  - SAMPLE: each cycle, for each bit, increment its vote counter if strap_i[b] = 1. After SAMPLES cycles, go to LOCK.
  - LOCK: hold cfg; resample = 1 moves to SETTLE.
- Voting:
  - cfg[b] = 1 iff ones-count > SAMPLES/2 (integer division).
  - mismatch = OR over bits of (count != 0 and count != SAMPLES).
  - Vote counter width = clog2(SAMPLES+1).
- Update on entering LOCK: cfg, mismatch and cfg_valid = 1 are all registered on the same edge as the LOCK entry.
- Latency: counting the first cycle with rst low as cycle 0:
  - SETTLE occupies cycles 0..SETTLE-1.
  - Samples are taken in cycles SETTLE..SETTLE+SAMPLES-1.
  - cfg_valid is high from cycle SETTLE+SAMPLES.
  - Defaults: samples in cycles 4, 5, 6; valid at cycle 7.
- busy = 1 exactly when state is SETTLE or SAMPLE, so busy = !cfg_valid except during reset.
- Resample:
  - In LOCK: cfg_valid drops on the next edge and busy rises.
  - cfg and mismatch keep their old values until the new lock, then update atomically.
  - resample while busy is ignored and not queued.
- Reset mid-operation (any state): immediate return to reset values; a pending sample set is discarded.
- strap_i is not synchronised internally. Tie-driven straps are static; pad-driven straps must be pre-synchronised upstream.

Optional Feature:
- Macro STRAP_PARITY_EN.
- Defined:
  - Adds input strap_par (1 bit) and output cfg_perr (1 bit, reset 0).
  - strap_par is voted exactly like a strap bit.
  - cfg_perr = XOR(voted cfg bits, voted par) != 0, i.e. even parity is expected.
  - cfg_perr is registered with cfg on LOCK entry.
  - The vote for strap_par also contributes to mismatch.
- Undefined: neither port exists and there is no parity logic.

Decomposition:
- Package strap_pkg:
  - state enum {ST_SETTLE, ST_SAMPLE, ST_LOCK}.
  - Function to compute vote-counter width from SAMPLES.
  - Localparam for the settle-counter width.
- Sub-module strap_vote: one per bit, generated WIDTH (+1 with parity) times.
  - Inputs: ck, clr, en, d.
  - Outputs: maj, unan.
  - Contains the ones-counter and comparators.
- Top level holds the FSM, counters and output registers.

Test Plan:
- Static straps: strap_i = 8'hA5 held, rst pulsed 2 cycles -> busy = 1 cycles 0..6; cycle 7: cfg = 8'hA5, cfg_valid = 1, mismatch = 0.
- Glitch vote: strap_i = 8'h0F in sample cycles 4 and 6, 8'h1F in cycle 5 -> cfg = 8'h0F, mismatch = 1.
- Resample: after lock at 8'hA5, change strap_i to 8'h3C and pulse resample:
  - cfg_valid = 0 next cycle while cfg still reads 8'hA5.
  - 7 cycles later, cfg = 8'h3C and cfg_valid = 1.
- Ignored request: resample pulsed in cycles 2 and 5 during initial sequence -> lock still at cycle 7, no second sequence.
- Mid-op reset: rst asserted at cycle 5 for 1 cycle -> all outputs return to reset values; new lock 7 cycles after rst falls.
- STRAP_PARITY_EN: strap_i = 8'h01, strap_par = 0 -> cfg_perr = 1; with strap_par = 1 -> cfg_perr = 0.
